// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: hits return data combinationally in the same cycle; a miss stalls fetch for 1 + LINE_WORDS beats minimum.
// The refill FSM holds mem_addr_o until mem_ack_i and tolerates ack gaps of any length; stall_o holds the core meanwhile.
module icache_dm #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    output logic [31:0]           instr_o,
    output logic                  stall_o,
    input  logic                  flush_i,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ack_i,
    input  logic [31:0]           mem_rdata_i,
    output logic [31:0]           miss_count_o
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_WIDTH - 2 - OFF_W - IDX_W;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] REFILL = 1'b1;

    logic [0:0]           state;
    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
    logic [31:0]          data_arr [NUM_LINES][LINE_WORDS];

    logic [TAG_W-1:0]     miss_tag;
    logic [IDX_W-1:0]     miss_index;
    logic [OFF_W-1:0]     cnt;
    logic [31:0]          miss_count;

    logic [OFF_W-1:0]     offset;
    logic [IDX_W-1:0]     index;
    logic [TAG_W-1:0]     tag;
    logic                 hit;
    logic                 miss;
    logic                 last_beat;
    logic                 beat_wr;
    logic                 unused_pc_lsb;

    assign offset        = pc_i[2 +: OFF_W];
    assign index         = pc_i[2 + OFF_W +: IDX_W];
    assign tag           = pc_i[ADDR_WIDTH-1 -: TAG_W];
    assign unused_pc_lsb = ^pc_i[1:0];

    assign hit       = req_i & valid[index] & (tag_arr[index] == tag);
    assign miss      = (state == IDLE) & req_i & ~hit & ~flush_i;
    assign last_beat = (cnt == OFF_W'(LINE_WORDS - 1));
    // A flush during refill discards the beat so stale words never reach a valid line.
    assign beat_wr   = (state == REFILL) & mem_ack_i & ~flush_i & ~rst_i;

    always_comb begin
        instr_o    = data_arr[index][offset];
        stall_o    = 1'b0;
        mem_req_o  = 1'b0;
        mem_addr_o = '0;
        if (state == REFILL) begin
            stall_o    = 1'b1;
            mem_req_o  = 1'b1;
            mem_addr_o = {miss_tag, miss_index, cnt, 2'b00};
        end else begin
            stall_o    = req_i & ~hit;
        end
    end

    assign miss_count_o = miss_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            valid      <= '0;
            cnt        <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_i) begin
                        valid <= '0;
                    end
                    if (miss) begin
                        miss_tag   <= tag;
                        miss_index <= index;
                        cnt        <= '0;
                        miss_count <= miss_count + 32'd1;
                        state      <= REFILL;
                    end
                end
                default: begin
                    if (flush_i) begin
                        valid <= '0;
                        cnt   <= '0;
                    end else if (mem_ack_i) begin
                        cnt <= cnt + 1'b1;
                        if (last_beat) begin
                            valid[miss_index] <= 1'b1;
                            state             <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (beat_wr) begin
            data_arr[miss_index][cnt] <= mem_rdata_i;
            if (last_beat) begin
                tag_arr[miss_index] <= miss_tag;
            end
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: directed test-plan sequences plus randomized traffic against an address-level cache model.
module tb_icache_dm;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic [31:0] instr_o;
    logic        stall_o;
    logic        flush_i = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic [31:0] miss_count_o;

    icache_dm #(.ADDR_WIDTH(32), .LINE_WORDS(4), .NUM_LINES(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .pc_i(pc_i),
        .instr_o(instr_o), .stall_o(stall_o), .flush_i(flush_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i), .miss_count_o(miss_count_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Cache model: which line bases are resident, and a pending refill tracked by base address and words received.
    bit          m_valid [16];
    logic [23:0] m_tag   [16];
    logic [31:0] m_data  [16][4];
    bit          m_busy;
    logic [31:0] m_base;
    int          m_got;
    logic [31:0] m_misses;

    logic        o_stall, o_mreq;
    logic [31:0] o_addr, o_instr, o_mc;
    logic [31:0] ack_addrs [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h00a00093;
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit rst, input bit req, input logic [31:0] pc, input bit flush, input bit ack);
        logic [3:0]  idx;
        logic [1:0]  off;
        logic [23:0] tg;
        bit          hit;
        logic        e_stall;
        @(negedge clk_i);
        rst_i = rst; req_i = req; pc_i = pc; flush_i = flush; mem_ack_i = ack;
        mem_rdata_i = mem_word(mem_addr_o);
        #1;
        o_stall = stall_o; o_mreq = mem_req_o; o_addr = mem_addr_o; o_instr = instr_o; o_mc = miss_count_o;
        idx = pc[7:4]; off = pc[3:2]; tg = pc[31:8];
        hit = req && m_valid[idx] && (m_tag[idx] == tg);
        if (cmp_en) begin
            e_stall = m_busy ? 1'b1 : (req && !hit);
            check("stall", {31'b0, o_stall}, {31'b0, e_stall});
            check("mem_req", {31'b0, o_mreq}, {31'b0, m_busy});
            check("mem_addr", o_addr, m_busy ? m_base + 32'(4 * m_got) : 32'h0);
            check("miss_count", o_mc, m_misses);
            if (!m_busy && hit) check("instr", o_instr, m_data[idx][off]);
        end
        @(posedge clk_i);
        if (rst) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_busy = 1'b0; m_got = 0; m_misses = '0;
        end else if (!m_busy) begin
            if (flush) foreach (m_valid[i]) m_valid[i] = 1'b0;
            if (req && !hit && !flush) begin
                m_busy = 1'b1; m_base = pc & ~32'hF; m_got = 0; m_misses++;
            end
        end else if (flush) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_got = 0;
        end else if (ack) begin
            m_data[m_base[7:4]][m_got] = mem_word(m_base + 32'(4 * m_got));
            m_got++;
            if (m_got == 4) begin
                m_valid[m_base[7:4]] = 1'b1;
                m_tag[m_base[7:4]] = m_base[31:8];
                m_busy = 1'b0;
            end
        end
    endtask

    // Presents pc until served; acks every period-th refill cycle. Records acked addresses.
    task automatic fetch(input logic [31:0] pc, input int period, output int stalls, output int acks);
        int  rc = 0;
        bit  done = 1'b0;
        bit  a;
        stalls = 0; acks = 0;
        ack_addrs.delete();
        for (int n = 0; n < 200 && !done; n++) begin
            a = (((rc + 1) % period) == 0);
            cycle(1'b0, 1'b1, pc, 1'b0, a);
            if (o_mreq) begin
                rc++;
                if (a) begin ack_addrs.push_back(o_addr); acks++; end
            end
            if (o_stall) stalls++;
            else done = 1'b1;
        end
        if (!done) check("fetch_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_line(input string name, input logic [31:0] base);
        check({name, "_nacks"}, 32'(ack_addrs.size()), 32'd4);
        for (int i = 0; i < 4 && i < ack_addrs.size(); i++)
            check({name, "_addr"}, ack_addrs[i], base + 32'(4 * i));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int st, ak;
        logic [31:0] pc;
        bit last_req;
        logic [31:0] mc_before;

        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cmp_en = 1'b1;
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("rst_stall", {31'b0, o_stall}, 32'd0);
        check("rst_mreq", {31'b0, o_mreq}, 32'd0);
        check("rst_mc", o_mc, 32'd0);

        // Cold miss
        fetch(32'h0, 1, st, ak);
        check("cold_stalls", 32'(st), 32'd5);
        check_line("cold", 32'h0);
        check("cold_instr", o_instr, 32'h00a00093);
        check("cold_mc", o_mc, 32'd1);

        // Hits after fill
        for (int i = 1; i < 4; i++) begin
            fetch(32'(4 * i), 1, st, ak);
            check("hit_stalls", 32'(st), 32'd0);
            check("hit_instr", o_instr, mem_word(32'(4 * i)));
            check("hit_mreq", {31'b0, o_mreq}, 32'd0);
            check("hit_mc", o_mc, 32'd1);
        end

        // Conflict on index 0
        fetch(32'h100, 1, st, ak);
        check("conf_stalls", 32'(st), 32'd5);
        check_line("conf", 32'h100);
        fetch(32'h0, 1, st, ak);
        check("conf_back_stalls", 32'(st), 32'd5);
        check_line("conf_back", 32'h0);
        check("conf_mc", o_mc, 32'd3);

        // Slow memory
        fetch(32'h200, 3, st, ak);
        check("slow_stalls", 32'(st), 32'd13);
        check_line("slow", 32'h200);
        check("slow_instr", o_instr, mem_word(32'h200));

        // Flush then re-fetch
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        fetch(32'h0, 1, st, ak);
        check("flush_stalls", 32'(st), 32'd5);
        check("flush_mc", o_mc, 32'd5);

        // Flush after the 2nd ack restarts the line
        cycle(1'b0, 1'b1, 32'h300, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'h300, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 32'h300, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 32'h300, 1'b1, 1'b0);
        check("midflush_addr", o_addr, 32'h308);
        fetch(32'h300, 1, st, ak);
        check_line("midflush", 32'h300);
        check("midflush_mc", o_mc, 32'd6);

        // Flush coinciding with the final ack
        cycle(1'b0, 1'b1, 32'h410, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'h410, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 32'h410, 1'b1, 1'b1);
        fetch(32'h410, 1, st, ak);
        check_line("lastflush", 32'h410);
        check("lastflush_instr", o_instr, mem_word(32'h410));

        // Reset mid-refill
        cycle(1'b0, 1'b1, 32'h500, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'h500, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 32'h500, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 32'h500, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("rstmid_mreq", {31'b0, o_mreq}, 32'd0);
        check("rstmid_stall", {31'b0, o_stall}, 32'd0);
        check("rstmid_mc", o_mc, 32'd0);
        fetch(32'h0, 1, st, ak);
        check("rstmid_stalls", 32'(st), 32'd5);
        check("rstmid_mc2", o_mc, 32'd1);

        // Randomized traffic over a small address pool to force hits and conflicts
        pc = 32'h0;
        last_req = 1'b0;
        mc_before = o_mc;
        for (int n = 0; n < 4000; n++) begin
            bit req, flush, ack, rst;
            req   = ($urandom_range(0, 9) != 0);
            if (!(last_req && o_stall && $urandom_range(0, 4) != 0))
                pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
                     (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            flush = ($urandom_range(0, 31) == 0);
            ack   = ($urandom_range(0, 1) == 1);
            rst   = ($urandom_range(0, 299) == 0);
            cycle(rst, req, pc, flush, ack);
            last_req = req;
        end
        if (o_mc == mc_before) check("random_no_misses", o_mc, mc_before + 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
